// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: parity-width helper, codeword bit maps, FSM states
// and default parameter values for secded_ram and its codec.
package ecc_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WB   = 2'd2
  } state_t;

  // Number of Hamming check bits: smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned ecc_p(int unsigned data_w);
    int unsigned r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r++;
    return r;
  endfunction

  // Hamming position (1-based, non-power-of-two) that holds data bit j.
  function automatic int unsigned data_pos(int unsigned j);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned i = 1; i < 256; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == j && pos == 0) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Codeword positions covered by check bit k (bit 0 never included).
  function automatic logic [63:0] cw_mask(int unsigned k);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 1; i < 64; i++)
      if (((i >> k) % 2) == 1) m = m | (64'(1) << i);
    return m;
  endfunction

  // Data bits (by data index) covered by check bit k.
  function automatic logic [63:0] data_mask(int unsigned k, int unsigned data_w);
    logic [63:0] m;
    m = '0;
    for (int unsigned j = 0; j < data_w; j++)
      if (((data_pos(j) >> k) % 2) == 1) m = m | (64'(1) << j);
    return m;
  endfunction

endpackage

// File: rtl/secded_ram_if.sv
// Request/response bundle between a requester (master) and secded_ram (slave).
// Signals: req_valid/ready/we/addr/wdata, inj_en/inj_mask, rsp_valid/rdata/sec/ded.
interface secded_ram_if import ecc_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = $clog2(DEF_DEPTH)
);
  localparam int unsigned CW_W = DATA_W + ecc_p(DATA_W) + 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              inj_en;
  logic [CW_W-1:0]   inj_mask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_sec;
  logic              rsp_ded;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, inj_en, inj_mask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_sec, rsp_ded
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, inj_en, inj_mask,
    output req_ready, rsp_valid, rsp_rdata, rsp_sec, rsp_ded
  );
endinterface

// File: rtl/secded_codec.sv
// Combinational extended-Hamming codec.
// enc_data -> enc_cw_c; dec_cw -> dec_data_c (corrected, raw on DED), dec_sec_c, dec_ded_c.
// Codeword bit 0 is overall parity; bits 1.. are Hamming positions.
module secded_codec import ecc_pkg::*; #(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned P      = ecc_p(DATA_W),
  localparam int unsigned CW_W   = DATA_W + P + 1
) (
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW_W-1:0]   enc_cw_c,
  input  logic [CW_W-1:0]   dec_cw,
  output logic [DATA_W-1:0] dec_data_c,
  output logic              dec_sec_c,
  output logic              dec_ded_c
);
  logic [CW_W-1:1] hw;
  logic [P-1:0]    syn;

  // Check bits from data; syndrome bits over the received codeword.
  for (genvar k = 0; k < P; k++) begin : g_chk
    localparam logic [63:0] DM = data_mask(k, DATA_W);
    localparam logic [63:0] CM = cw_mask(k);
    assign hw[2**k] = ^(enc_data & DM[DATA_W-1:0]);
    assign syn[k]   = ^(dec_cw & CM[CW_W-1:0]);
  end

  // Data placement, and extraction with a flip when the syndrome names the position.
  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    localparam int unsigned POS = data_pos(j);
    assign hw[POS]       = enc_data[j];
    assign dec_data_c[j] = dec_cw[POS] ^ (dec_sec_c && (syn == P'(POS)));
  end

  assign enc_cw_c = {hw, ^hw};

  // Odd overall parity means a single error (syn = 0: parity bit itself).
  assign dec_sec_c = ^dec_cw;
  assign dec_ded_c = !dec_sec_c && (syn != '0);
endmodule

// File: rtl/secded_ram.sv
// SECDED-protected single-port RAM with scrub-on-correct writeback.
// Ports: clk, rst_n, bus (secded_ram_if.slave), sec_cnt / ded_cnt saturating counters.
module secded_ram import ecc_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  secded_ram_if.slave      bus,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);
  localparam int unsigned P    = ecc_p(DATA_W);
  localparam int unsigned CW_W = DATA_W + P + 1;

  state_t            state_q, state_d;
  logic [CW_W-1:0]   mem [DEPTH];
  logic [CW_W-1:0]   rd_cw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              req_ready_q, rsp_valid_q, rsp_sec_q, rsp_ded_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;

  logic              rd_c, mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] enc_data_c, dec_data_c;
  logic [CW_W-1:0]   enc_cw_c, mem_wdata_c;
  logic              dec_sec_c, dec_ded_c;
  logic [DATA_W-1:0] unused_dec_data_c;
  logic              unused_dec_sec_c, unused_dec_ded_c;
  logic [CW_W-1:0]   unused_enc_cw_c;

  secded_codec #(.DATA_W(DATA_W)) u_enc (
    .enc_data   (enc_data_c),
    .enc_cw_c   (enc_cw_c),
    .dec_cw     ('0),
    .dec_data_c (unused_dec_data_c),
    .dec_sec_c  (unused_dec_sec_c),
    .dec_ded_c  (unused_dec_ded_c)
  );

  secded_codec #(.DATA_W(DATA_W)) u_dec (
    .enc_data   ('0),
    .enc_cw_c   (unused_enc_cw_c),
    .dec_cw     (rd_cw_q),
    .dec_data_c (dec_data_c),
    .dec_sec_c  (dec_sec_c),
    .dec_ded_c  (dec_ded_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and array write-port steering (bus write in IDLE, scrub in WB).
  always_comb begin
    state_d     = state_q;
    rd_c        = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.req_addr;
    enc_data_c  = bus.req_wdata;
    mem_wdata_c = enc_cw_c;
    unique case (state_q)
      IDLE: begin
        rd_c     = bus.req_valid && !bus.req_we;
        mem_we_c = bus.req_valid && bus.req_we;
        if (bus.inj_en) mem_wdata_c = enc_cw_c ^ bus.inj_mask;
        if (rd_c) state_d = RD;
      end
      RD: state_d = dec_sec_c ? WB : IDLE;
      WB: begin
        state_d     = IDLE;
        mem_we_c    = 1'b1;
        mem_waddr_c = addr_q;
        enc_data_c  = wb_data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array with registered read port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    if (rd_c)     rd_cw_q <= mem[bus.req_addr];
  end

  // Response, writeback data and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_sec_q   <= 1'b0;
      rsp_ded_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wb_data_q   <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_q == RD);
      rsp_sec_q   <= (state_q == RD) && dec_sec_c;
      rsp_ded_q   <= (state_q == RD) && dec_ded_c;
      if (rd_c) addr_q <= bus.req_addr;
      if (state_q == RD) begin
        rsp_rdata_q <= dec_data_c;
        wb_data_q   <= dec_data_c;
        if (dec_sec_c && sec_cnt_q != '1) sec_cnt_q <= sec_cnt_q + CNT_W'(1);
        if (dec_ded_c && ded_cnt_q != '1) ded_cnt_q <= ded_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_sec   = rsp_sec_q;
  assign bus.rsp_ded   = rsp_ded_q;
  assign sec_cnt       = sec_cnt_q;
  assign ded_cnt       = ded_cnt_q;
endmodule

// File: tb/tb_secded_ram.sv
// Directed bench for secded_ram: a default instance plus a CNT_W = 2 instance
// that sees the same request stream, to observe counter saturation.
module tb_secded_ram;
  import ecc_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned CWW = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  secded_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  secded_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  logic [7:0] sec_cnt, ded_cnt;
  logic [1:0] sec_cnt_s, ded_cnt_s;

  secded_ram #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  secded_ram #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .sec_cnt(sec_cnt_s), .ded_cnt(ded_cnt_s)
  );

  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_we    = bus.req_we;
  assign bus_s.req_addr  = bus.req_addr;
  assign bus_s.req_wdata = bus.req_wdata;
  assign bus_s.inj_en    = bus.inj_en;
  assign bus_s.inj_mask  = bus.inj_mask;

  int total = 0;
  int bad   = 0;
  int n_sec = 0;
  int n_ded = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat3(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 32'(bus.req_ready), 1);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 0);
    chk({tag, ".sec"}, 32'(bus.rsp_sec), 0);
    chk({tag, ".ded"}, 32'(bus.rsp_ded), 0);
    chk({tag, ".sec_cnt"}, 32'(sec_cnt), 0);
    chk({tag, ".ded_cnt"}, 32'(ded_cnt), 0);
    chk({tag, ".sat_sec_cnt"}, 32'(sec_cnt_s), 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CWW-1:0] m);
    @(negedge clk);
    chk("wr.ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.inj_en    = (m != '0);
    bus.inj_mask  = m;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.inj_en    = 1'b0;
    bus.inj_mask  = '0;
  endtask

  // Read with full timing checks; optionally pulls rst_n while the scrub is pending.
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                    input bit exp_sec, input bit exp_ded, input bit rst_in_wb);
    @(negedge clk);
    chk({tag, ".ready_in"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".busy"}, 32'(bus.req_ready), 0);
    chk({tag, ".early_rsp"}, 32'(bus.rsp_valid), 0);
    if (exp_sec) n_sec++;
    if (exp_ded) n_ded++;
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(exp_d));
    chk({tag, ".sec"}, 32'(bus.rsp_sec), 32'(exp_sec));
    chk({tag, ".ded"}, 32'(bus.rsp_ded), 32'(exp_ded));
    chk({tag, ".ready_rsp"}, 32'(bus.req_ready), 32'(!exp_sec));
    chk({tag, ".sec_cnt"}, 32'(sec_cnt), 32'(n_sec));
    chk({tag, ".ded_cnt"}, 32'(ded_cnt), 32'(n_ded));
    chk({tag, ".sat_sec"}, 32'(sec_cnt_s), sat3(n_sec));
    chk({tag, ".sat_ded"}, 32'(ded_cnt_s), sat3(n_ded));
    chk({tag, ".sat_rdata"}, 32'(bus_s.rsp_rdata), 32'(exp_d));
    if (rst_in_wb) begin
      rst_n = 1'b0;
      #1;
      chk_reset({tag, ".rst"});
      n_sec = 0;
      n_ded = 0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      chk({tag, ".rsp_drop"}, 32'(bus.rsp_valid), 0);
      chk({tag, ".sec_drop"}, 32'(bus.rsp_sec), 0);
      chk({tag, ".ready_out"}, 32'(bus.req_ready), 1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.inj_en    = 1'b0;
    bus.inj_mask  = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    wr(4'd3, 8'hA5, 13'h0000);
    rd("clean", 4'd3, 8'hA5, 1'b0, 1'b0, 1'b0);

    wr(4'd7, 8'h3C, 13'h0020);
    rd("sec_d1", 4'd7, 8'h3C, 1'b1, 1'b0, 1'b0);
    rd("scrubbed", 4'd7, 8'h3C, 1'b0, 1'b0, 1'b0);

    wr(4'd2, 8'h55, 13'h0006);
    rd("ded_a", 4'd2, 8'h55, 1'b0, 1'b1, 1'b0);
    rd("ded_b", 4'd2, 8'h55, 1'b0, 1'b1, 1'b0);

    wr(4'd5, 8'h81, 13'h0001);
    rd("sec_par", 4'd5, 8'h81, 1'b1, 1'b0, 1'b0);
    rd("par_clean", 4'd5, 8'h81, 1'b0, 1'b0, 1'b0);

    wr(4'd9, 8'h99, 13'h0040);
    rd("sec_rst", 4'd9, 8'h99, 1'b1, 1'b0, 1'b1);
    rd("sec_kept", 4'd9, 8'h99, 1'b1, 1'b0, 1'b0);
    rd("rst_scrub", 4'd9, 8'h99, 1'b0, 1'b0, 1'b0);

    wr(4'd4, 8'h0F, 13'h0100);
    rd("sec_c8", 4'd4, 8'h0F, 1'b1, 1'b0, 1'b0);
    wr(4'd6, 8'h80, 13'h1000);
    rd("sec_d7", 4'd6, 8'h80, 1'b1, 1'b0, 1'b0);
    wr(4'd7, 8'h3C, 13'h0020);
    rd("sec_sat", 4'd7, 8'h3C, 1'b1, 1'b0, 1'b0);

    wr(4'd11, 8'hF0, 13'h0018);
    rd("ded_raw_a", 4'd11, 8'hF1, 1'b0, 1'b1, 1'b0);
    rd("ded_raw_b", 4'd11, 8'hF1, 1'b0, 1'b1, 1'b0);

    wr(4'd0, 8'h00, 13'h0000);
    wr(4'd15, 8'hFF, 13'h0000);
    wr(4'd12, 8'h5A, 13'h0000);
    rd("addr0", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rd("addr15", 4'd15, 8'hFF, 1'b0, 1'b0, 1'b0);
    rd("addr12", 4'd12, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
